decode_queue: RTL and testbench
===============================

# decode_queue

Decoded-instruction queue between the decode mux and the issue/dispatch stage. It captures one unified decoded instruction per cycle from the decode mux output bus and holds up to `queueDepth` entries in order. It presents the oldest entry to issue under a valid/ready handshake and back-pressures decode with a registered stall that leaves one slot of skid. A flush empties the queue on branch redirect.

## Interface
Parameters:
- addressWidth, 64, instruction address width
- opcodeSize, 12, decoded opcode width
- funcUnitCodeSize, 3, functional-unit code width
- instructionCounterWidth, 64, major ID width
- instMinIdWidth, 7, minor ID and micro-op count width
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- regAccessPatternSize, 2, per-operand rw field width
- bodyWidth, 64, operand body width
- queueDepth, 8, number of entries; must be a power of 2 and ≥ 2

Ports:
- clock_i  in  1  clock; all state updates on the rising edge
- reset_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all entries
- enable_i  in  1  incoming instruction valid
- opcode_i, address_i, funcUnitType_i, majID_i, minID_i, numMicroOps_i, is64Bit_i, pid_i, tid_i  in  as parameters  instruction fields
- op1rw_i..op4rw_i  in  2 each  operand access pattern; 2'b10 = read, 2'b01 = write
- op1IsReg_i..op4IsReg_i  in  1 each  operand is a register
- body_i  in  bodyWidth  operand body
- stall_o  out  1  registered back-pressure to decode
- issueReady_i  in  1  issue accepts the head entry this cycle
- valid_o  out  1  head entry valid
- the same field set with the `_o` suffix  out  same widths  head entry contents
- count_o  out  log2(queueDepth)+1  occupancy
- overflow_o  out  1  sticky error flag: a write arrived while the queue was full

## Operation
- Storage: a circular buffer of registers with headPtr and tailPtr, each log2(queueDepth) bits and wrapping modulo queueDepth, plus a separate count register. Full means count == queueDepth. Empty means count == 0.
- Push: enable_i && !full. The entry is written at tailPtr and tailPtr increments.
- Pop: valid_o && issueReady_i. headPtr increments.
- Simultaneous push and pop: both happen and count is unchanged. This includes the full case, where the pop frees a slot and the push is accepted in the same cycle.
- Push while full and no pop: the data is dropped, overflow_o is set to 1, and it stays at 1 until reset.
- Output fields are driven combinationally from the entry at headPtr. When valid_o = 0 they are don't-care; the bench must not check them.
- stall_o is registered. It is 1 in the cycle after any cycle whose next count is ≥ queueDepth−1. This leaves one slot for the instruction already in flight from decode.
- Priority, highest first: reset_i, then flush_i, then push/pop.
- Flush: headPtr = tailPtr = count = 0 and stall_o = 0. Any push in the same cycle is discarded. overflow_o is unchanged.

## Timing
- Reset values: valid_o = 0, count_o = 0, stall_o = 0, overflow_o = 0, both pointers = 0. Field outputs reflect entry 0; their contents are don't-care.
- Reset applied mid-operation: on the next edge everything returns to the reset values and all entries are lost.
- Latency without bypass: an instruction pushed at edge N appears on valid_o/fields after edge N, i.e. one cycle later.
- Throughput: one push and one pop per cycle, sustained indefinitely.
- Wrap: the pointer at queueDepth−1 increments to 0; no bubble is inserted at wrap.

## Configuration
- Macro `DECODE_QUEUE_BYPASS_EN`.
- Defined:
  - When the queue is empty and enable_i = 1, the incoming fields drive the outputs combinationally and valid_o = 1 in the same cycle.
  - If issueReady_i = 1 in that cycle, the instruction is consumed and not stored; count stays 0.
  - If issueReady_i = 0, the instruction is stored normally.
  - A flush in the same cycle forces valid_o = 0.
- Undefined: no combinational path from the inputs to the outputs; minimum latency is 1 cycle.

## Test plan
- Reset then idle: all outputs at their reset values, including count_o = 0 and valid_o = 0.
- Single instruction (opcode 4, funcUnitType 1, op1rw 2'b01, body 64'hA5): with issueReady_i = 0 it appears one cycle later with identical fields and count_o = 1. Raising issueReady_i for one cycle pops it; count_o = 0 and valid_o = 0.
- Fill to capacity with queueDepth = 8 and issueReady_i = 0, pushing majID values 0–7:
  - stall_o rises in the cycle after the push that made count 7;
  - a 9th push sets overflow_o = 1 and count_o stays 8;
  - draining yields majID 0–7 in order.
- Full plus simultaneous push and pop: the oldest entry is popped, the new entry is accepted, count_o stays 8, overflow_o stays 0.
- Continuous streaming: 20 instructions with issueReady_i = 1 cross the pointer wrap twice with no dropped or reordered majIDs.
- Flush with 5 entries and a push in the same cycle: next cycle count_o = 0, valid_o = 0, stall_o = 0. With `DECODE_QUEUE_BYPASS_EN` defined and the queue empty, a push with issueReady_i = 1 shows valid_o = 1 in the same cycle and count_o stays 0.

Source files
------------

// File: rtl/decode_queue_if.sv
// Decode-to-issue bundle for decode_queue: decode-side inputs, issue-side head outputs, status.
// master drives the queue (decode/issue side); slave is the queue itself.
interface decode_queue_if #(
  parameter int addressWidth            = 64,
  parameter int opcodeSize              = 12,
  parameter int funcUnitCodeSize        = 3,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int regAccessPatternSize    = 2,
  parameter int bodyWidth               = 64,
  parameter int queueDepth              = 8
) ();
  localparam int cntW = $clog2(queueDepth) + 1;

  logic                               flush_i;
  logic                               enable_i;
  logic [opcodeSize-1:0]              opcode_i;
  logic [addressWidth-1:0]            address_i;
  logic [funcUnitCodeSize-1:0]        funcUnitType_i;
  logic [instructionCounterWidth-1:0] majID_i;
  logic [instMinIdWidth-1:0]          minID_i;
  logic [instMinIdWidth-1:0]          numMicroOps_i;
  logic                               is64Bit_i;
  logic [PidSize-1:0]                 pid_i;
  logic [TidSize-1:0]                 tid_i;
  logic [regAccessPatternSize-1:0]    op1rw_i, op2rw_i, op3rw_i, op4rw_i;
  logic                               op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i;
  logic [bodyWidth-1:0]               body_i;
  logic                               stall_o;
  logic                               issueReady_i;
  logic                               valid_o;
  logic [opcodeSize-1:0]              opcode_o;
  logic [addressWidth-1:0]            address_o;
  logic [funcUnitCodeSize-1:0]        funcUnitType_o;
  logic [instructionCounterWidth-1:0] majID_o;
  logic [instMinIdWidth-1:0]          minID_o;
  logic [instMinIdWidth-1:0]          numMicroOps_o;
  logic                               is64Bit_o;
  logic [PidSize-1:0]                 pid_o;
  logic [TidSize-1:0]                 tid_o;
  logic [regAccessPatternSize-1:0]    op1rw_o, op2rw_o, op3rw_o, op4rw_o;
  logic                               op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o;
  logic [bodyWidth-1:0]               body_o;
  logic [cntW-1:0]                    count_o;
  logic                               overflow_o;

  modport master (
    output flush_i, enable_i, opcode_i, address_i, funcUnitType_i, majID_i, minID_i,
           numMicroOps_i, is64Bit_i, pid_i, tid_i, op1rw_i, op2rw_i, op3rw_i, op4rw_i,
           op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i, body_i, issueReady_i,
    input  stall_o, valid_o, opcode_o, address_o, funcUnitType_o, majID_o, minID_o,
           numMicroOps_o, is64Bit_o, pid_o, tid_o, op1rw_o, op2rw_o, op3rw_o, op4rw_o,
           op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, body_o, count_o, overflow_o
  );

  modport slave (
    input  flush_i, enable_i, opcode_i, address_i, funcUnitType_i, majID_i, minID_i,
           numMicroOps_i, is64Bit_i, pid_i, tid_i, op1rw_i, op2rw_i, op3rw_i, op4rw_i,
           op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i, body_i, issueReady_i,
    output stall_o, valid_o, opcode_o, address_o, funcUnitType_o, majID_o, minID_o,
           numMicroOps_o, is64Bit_o, pid_o, tid_o, op1rw_o, op2rw_o, op3rw_o, op4rw_o,
           op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, body_o, count_o, overflow_o
  );
endinterface

// File: rtl/decode_queue.sv
// In-order decoded-instruction queue between decode mux and issue, with registered skid stall.
// Optional DECODE_QUEUE_BYPASS_EN: an empty queue forwards the incoming instruction combinationally.
module decode_queue #(
  parameter int addressWidth            = 64,
  parameter int opcodeSize              = 12,
  parameter int funcUnitCodeSize        = 3,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int regAccessPatternSize    = 2,
  parameter int bodyWidth               = 64,
  parameter int queueDepth              = 8
) (
  input logic           clock_i,
  input logic           reset_i,
  decode_queue_if.slave bus
);
  localparam int ptrW = $clog2(queueDepth);
  localparam int cntW = ptrW + 1;

  typedef struct packed {
    logic [opcodeSize-1:0]              opcode;
    logic [addressWidth-1:0]            address;
    logic [funcUnitCodeSize-1:0]        funcUnitType;
    logic [instructionCounterWidth-1:0] majID;
    logic [instMinIdWidth-1:0]          minID;
    logic [instMinIdWidth-1:0]          numMicroOps;
    logic                               is64Bit;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
    logic [regAccessPatternSize-1:0]    op1rw, op2rw, op3rw, op4rw;
    logic                               op1IsReg, op2IsReg, op3IsReg, op4IsReg;
    logic [bodyWidth-1:0]               body;
  } instT;

  instT            mem [queueDepth];
  instT            inInst, headInst, outInst;
  logic [ptrW-1:0] headPtr, tailPtr;
  logic [cntW-1:0] count, nextCount;
  logic            stall, overflow;
  logic            full, empty, valid, bypassTake, popStored, pushStored, dropWrite;

  assign inInst = '{opcode: bus.opcode_i, address: bus.address_i, funcUnitType: bus.funcUnitType_i,
                    majID: bus.majID_i, minID: bus.minID_i, numMicroOps: bus.numMicroOps_i,
                    is64Bit: bus.is64Bit_i, pid: bus.pid_i, tid: bus.tid_i,
                    op1rw: bus.op1rw_i, op2rw: bus.op2rw_i, op3rw: bus.op3rw_i, op4rw: bus.op4rw_i,
                    op1IsReg: bus.op1IsReg_i, op2IsReg: bus.op2IsReg_i,
                    op3IsReg: bus.op3IsReg_i, op4IsReg: bus.op4IsReg_i, body: bus.body_i};

  assign headInst = mem[headPtr];
  assign full     = count == cntW'(queueDepth);
  assign empty    = count == '0;

`ifdef DECODE_QUEUE_BYPASS_EN
  // Empty queue: present the incoming instruction directly; if taken now it is never stored.
  assign valid      = !empty || (bus.enable_i && !bus.flush_i);
  assign outInst    = empty ? inInst : headInst;
  assign bypassTake = empty && bus.enable_i && bus.issueReady_i;
`else
  assign valid      = !empty;
  assign outInst    = headInst;
  assign bypassTake = 1'b0;
`endif

  // A pop frees the slot the same cycle, so a full queue still accepts a push alongside a pop.
  assign popStored  = !empty && bus.issueReady_i;
  assign pushStored = bus.enable_i && !bypassTake && (!full || popStored);
  assign dropWrite  = bus.enable_i && full && !popStored;

  always_comb begin
    nextCount = count;
    case ({pushStored, popStored})
      2'b10:   nextCount = count + cntW'(1);
      2'b01:   nextCount = count - cntW'(1);
      default: nextCount = count;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      count    <= '0;
      stall    <= 1'b0;
      overflow <= 1'b0;
    end else if (bus.flush_i) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      stall   <= 1'b0;
    end else begin
      if (pushStored) tailPtr <= tailPtr + ptrW'(1);
      if (popStored)  headPtr <= headPtr + ptrW'(1);
      count <= nextCount;
      // Stall one entry early so the instruction already in flight from decode still fits.
      stall <= nextCount >= cntW'(queueDepth - 1);
      if (dropWrite) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i && !bus.flush_i && pushStored) mem[tailPtr] <= inInst;
  end

  assign bus.valid_o        = valid;
  assign bus.stall_o        = stall;
  assign bus.count_o        = count;
  assign bus.overflow_o     = overflow;
  assign bus.opcode_o       = outInst.opcode;
  assign bus.address_o      = outInst.address;
  assign bus.funcUnitType_o = outInst.funcUnitType;
  assign bus.majID_o        = outInst.majID;
  assign bus.minID_o        = outInst.minID;
  assign bus.numMicroOps_o  = outInst.numMicroOps;
  assign bus.is64Bit_o      = outInst.is64Bit;
  assign bus.pid_o          = outInst.pid;
  assign bus.tid_o          = outInst.tid;
  assign bus.op1rw_o        = outInst.op1rw;
  assign bus.op2rw_o        = outInst.op2rw;
  assign bus.op3rw_o        = outInst.op3rw;
  assign bus.op4rw_o        = outInst.op4rw;
  assign bus.op1IsReg_o     = outInst.op1IsReg;
  assign bus.op2IsReg_o     = outInst.op2IsReg;
  assign bus.op3IsReg_o     = outInst.op3IsReg;
  assign bus.op4IsReg_o     = outInst.op4IsReg;
  assign bus.body_o         = outInst.body;
endmodule

// File: tb/tb_decode_queue.sv
// Randomized bench for decode_queue against a queue-based reference model; covers
// DECODE_QUEUE_BYPASS_EN when the macro is defined for the build.
module tb_decode_queue;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [11:0] opcode;
    logic [63:0] address;
    logic [2:0]  funcUnitType;
    logic [63:0] majID;
    logic [6:0]  minID;
    logic [6:0]  numMicroOps;
    logic        is64Bit;
    logic [19:0] pid;
    logic [15:0] tid;
    logic [1:0]  op1rw, op2rw, op3rw, op4rw;
    logic        op1IsReg, op2IsReg, op3IsReg, op4IsReg;
    logic [63:0] body;
  } tbInst;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  tbInst obs;
  tbInst q[$];
  logic  ovf = 1'b0;
  logic  expStall = 1'b0;
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  decode_queue_if #(.queueDepth(DEPTH)) bus ();
  decode_queue #(.queueDepth(DEPTH)) dut (.clock_i(clk), .reset_i(rst), .bus(bus));

  assign obs = '{opcode: bus.opcode_o, address: bus.address_o, funcUnitType: bus.funcUnitType_o,
                 majID: bus.majID_o, minID: bus.minID_o, numMicroOps: bus.numMicroOps_o,
                 is64Bit: bus.is64Bit_o, pid: bus.pid_o, tid: bus.tid_o,
                 op1rw: bus.op1rw_o, op2rw: bus.op2rw_o, op3rw: bus.op3rw_o, op4rw: bus.op4rw_o,
                 op1IsReg: bus.op1IsReg_o, op2IsReg: bus.op2IsReg_o,
                 op3IsReg: bus.op3IsReg_o, op4IsReg: bus.op4IsReg_o, body: bus.body_o};

  task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tbInst randInst();
    tbInst x;
    x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return x;
  endfunction

  task automatic drive(input tbInst x);
    bus.opcode_i = x.opcode;       bus.address_i = x.address;   bus.funcUnitType_i = x.funcUnitType;
    bus.majID_i = x.majID;         bus.minID_i = x.minID;       bus.numMicroOps_i = x.numMicroOps;
    bus.is64Bit_i = x.is64Bit;     bus.pid_i = x.pid;           bus.tid_i = x.tid;
    bus.op1rw_i = x.op1rw;         bus.op2rw_i = x.op2rw;       bus.op3rw_i = x.op3rw;
    bus.op4rw_i = x.op4rw;         bus.op1IsReg_i = x.op1IsReg; bus.op2IsReg_i = x.op2IsReg;
    bus.op3IsReg_i = x.op3IsReg;   bus.op4IsReg_i = x.op4IsReg; bus.body_i = x.body;
  endtask

  // One clock: apply inputs, check outputs against the model, advance the model across the edge.
  task automatic cycle(input logic r, input logic fl, input logic en, input logic rdy, input tbInst x);
    logic expValid, wasEmpty, wasFull, pop;
    rst = r; bus.flush_i = fl; bus.enable_i = en; bus.issueReady_i = rdy;
    drive(x);
    #1;
    wasEmpty = q.size() == 0;
    wasFull  = q.size() == DEPTH;
    expValid = !wasEmpty;
`ifdef DECODE_QUEUE_BYPASS_EN
    if (wasEmpty && en && !fl) expValid = 1'b1;
`endif
    chk("valid", bus.valid_o, expValid);
    if (expValid) chk("head", obs, wasEmpty ? x : q[0]);
    chk("count", bus.count_o, q.size());
    chk("stall", bus.stall_o, expStall);
    chk("overflow", bus.overflow_o, ovf);
    if (r) begin
      q.delete();
      ovf = 1'b0;
    end else if (fl) begin
      q.delete();
    end else begin
      pop = expValid && rdy;
      if (pop && !wasEmpty) void'(q.pop_front());
      if (en && !(pop && wasEmpty)) begin
        if (!wasFull || pop) q.push_back(x);
        else ovf = 1'b1;
      end
    end
    expStall = q.size() >= DEPTH - 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbInst z, x;
    int rdyPct;
    z = '0;
    bus.flush_i = 1'b0; bus.enable_i = 1'b0; bus.issueReady_i = 1'b0;
    drive(z);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset then idle
    repeat (3) cycle(0, 0, 0, 0, z);

    // single instruction, then pop
    x = randInst(); x.opcode = 12'd4; x.funcUnitType = 3'd1; x.op1rw = 2'b01; x.body = 64'hA5;
    cycle(0, 0, 1, 0, x);
    cycle(0, 0, 0, 0, z);
    cycle(0, 0, 0, 1, z);
    cycle(0, 0, 0, 0, z);

    // fill to capacity, overflow on 9th push, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      x = randInst(); x.majID = 64'(i);
      cycle(0, 0, 1, 0, x);
    end
    x = randInst(); x.majID = 64'd99;
    cycle(0, 0, 1, 0, x);
    cycle(0, 0, 0, 0, z);
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 1, z);
    cycle(1, 0, 0, 0, z);
    cycle(0, 0, 0, 0, z);

    // full plus simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) begin
      x = randInst(); x.majID = 64'(10 + i);
      cycle(0, 0, 1, 0, x);
    end
    x = randInst(); x.majID = 64'd50;
    cycle(0, 0, 1, 1, x);
    cycle(0, 0, 0, 0, z);
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 1, z);

    // continuous streaming across pointer wrap
    for (int i = 0; i < 20; i++) begin
      x = randInst(); x.majID = 64'(100 + i);
      cycle(0, 0, 1, 1, x);
    end
    repeat (2) cycle(0, 0, 0, 1, z);

    // flush with 5 entries and a same-cycle push
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, randInst());
    cycle(0, 1, 1, 0, randInst());
    cycle(0, 0, 0, 0, z);

    // empty queue, push with issue ready (bypass when enabled)
    cycle(0, 0, 1, 1, randInst());
    repeat (2) cycle(0, 0, 0, 1, z);

    // randomized traffic with varying back-pressure, flushes and rare resets
    rdyPct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) rdyPct = $urandom_range(10, 95);
      cycle(($urandom % 600) == 0, ($urandom % 50) == 0, ($urandom % 4) != 0,
            $urandom_range(0, 99) < rdyPct, randInst());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
